// File: rtl/bcd_entry_editor_pkg.sv
// Shared types and constants for the BCD entry editor: FSM encoding, cursor
// positions, digit/value widths and the init-value clamp helper.
package bcd_entry_editor_pkg;

    localparam int DIG_W = 4;
    localparam int VAL_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic [1:0] CUR_L_TENS = 2'd0;
    localparam logic [1:0] CUR_L_ONES = 2'd1;
    localparam logic [1:0] CUR_R_TENS = 2'd2;
    localparam logic [1:0] CUR_R_ONES = 2'd3;

    function automatic logic [VAL_W-1:0] clamp_val(input logic [VAL_W-1:0] v,
                                                   input int unsigned      lim);
        return (v > VAL_W'(lim)) ? VAL_W'(lim) : v;
    endfunction

endpackage

// File: rtl/bcd_entry_editor_edit_field.sv
// One 2-digit BCD field: load, per-digit wrap inc/dec (tens wraps at MAX/10),
// binary value and in-range flag. Updates one cycle after a request.
module bcd_entry_editor_edit_field
    import bcd_entry_editor_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIG_W-1:0] ld_tens,
    input  logic [DIG_W-1:0] ld_ones,
    input  logic             inc_tens,
    input  logic             inc_ones,
    input  logic             dec_tens,
    input  logic             dec_ones,
    output logic [DIG_W-1:0] tens,
    output logic [DIG_W-1:0] ones,
    output logic [VAL_W-1:0] value,
    output logic             in_range
);

    localparam logic [DIG_W-1:0] TENS_LIM = DIG_W'(MAX / 10);

    logic [DIG_W-1:0] tens_q, tens_d, ones_q, ones_d;

    always_comb begin
        tens_d = tens_q;
        ones_d = ones_q;
        if (load) begin
            tens_d = ld_tens;
            ones_d = ld_ones;
        end else if (inc_tens) begin
            tens_d = (tens_q >= TENS_LIM) ? '0 : tens_q + DIG_W'(1);
        end else if (dec_tens) begin
            tens_d = (tens_q == '0) ? TENS_LIM : tens_q - DIG_W'(1);
        end else if (inc_ones) begin
            ones_d = (ones_q >= DIG_W'(9)) ? '0 : ones_q + DIG_W'(1);
        end else if (dec_ones) begin
            ones_d = (ones_q == '0) ? DIG_W'(9) : ones_q - DIG_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens     = tens_q;
    assign ones     = ones_q;
    assign value    = VAL_W'(tens_q) * VAL_W'(10) + VAL_W'(ones_q);
    assign in_range = (value <= VAL_W'(MAX));

endmodule

// File: rtl/bin2bcd.sv
// Binary to two-digit BCD, combinational; input must already be limited to 0..99.
// Zero latency, no flow control.
module bin2bcd
    import bcd_entry_editor_pkg::*;
(
    input  logic [VAL_W-1:0] bin,
    output logic [DIG_W-1:0] tens,
    output logic [DIG_W-1:0] ones
);

    logic [VAL_W-1:0] rem;

    always_comb begin
        rem  = bin;
        tens = '0;
        for (int i = 0; i < 9; i++) begin
            if (rem >= VAL_W'(10)) begin
                rem  = rem - VAL_W'(10);
                tens = tens + DIG_W'(1);
            end
        end
        ones = DIG_W'(rem);
    end

endmodule

// File: rtl/bcd_entry_editor.sv
// Button-driven two-field BCD editor producing binary load values on commit.
// Commit strobe one cycle after the CHECK state; buttons ignored outside EDIT.
module bcd_entry_editor
    import bcd_entry_editor_pkg::*;
#(
    parameter int MAX_L      = 23,
    parameter int MAX_R      = 59,
    parameter int BLINK_HALF = 50
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [VAL_W-1:0] init_L,
    input  logic [VAL_W-1:0] init_R,
    input  logic             btn_next,
    input  logic             btn_inc,
    input  logic             btn_dec,
    input  logic             btn_ok,
    input  logic             btn_cancel,
    output logic             edit_active,
    output logic [1:0]       cursor,
    output logic [15:0]      digits,
    output logic [3:0]       blank_mask,
    output logic [VAL_W-1:0] load_L,
    output logic [VAL_W-1:0] load_R,
    output logic             load_valid,
    output logic             err
);

    localparam int CW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;

    state_t           state_q, state_d;
    logic [1:0]       cursor_q, cursor_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic [VAL_W-1:0] load_L_q, load_L_d, load_R_q, load_R_d;
    logic             load_valid_q, load_valid_d, err_q, err_d;

    logic             in_edit, reload, btn_ok_edit;
    logic             act_cancel, act_ok, act_next, act_inc, act_dec, act_any;
    logic [DIG_W-1:0] il_tens, il_ones, ir_tens, ir_ones;
    logic [DIG_W-1:0] l_tens, l_ones, r_tens, r_ones;
    logic [VAL_W-1:0] l_val, r_val;
    logic             l_ok, r_ok;

    // Start reloads from IDLE or EDIT and outranks every button.
    assign in_edit     = (state_q == ST_EDIT);
    assign reload      = start && (state_q != ST_CHECK);
    assign btn_ok_edit = in_edit && !start;
    assign act_cancel  = btn_ok_edit && btn_cancel;
    assign act_ok      = btn_ok_edit && !btn_cancel && btn_ok;
    assign act_next    = btn_ok_edit && !btn_cancel && !btn_ok && btn_next;
    assign act_inc     = btn_ok_edit && !btn_cancel && !btn_ok && !btn_next && btn_inc;
    assign act_dec     = btn_ok_edit && !btn_cancel && !btn_ok && !btn_next && !btn_inc && btn_dec;
    assign act_any     = act_cancel || act_ok || act_next || act_inc || act_dec;

    bin2bcd u_init_l (.bin(clamp_val(init_L, MAX_L)), .tens(il_tens), .ones(il_ones));
    bin2bcd u_init_r (.bin(clamp_val(init_R, MAX_R)), .tens(ir_tens), .ones(ir_ones));

    bcd_entry_editor_edit_field #(.MAX(MAX_L)) u_field_l (
        .clk(clk), .rst_n(rst_n), .load(reload), .ld_tens(il_tens), .ld_ones(il_ones),
        .inc_tens(act_inc && cursor_q == CUR_L_TENS), .inc_ones(act_inc && cursor_q == CUR_L_ONES),
        .dec_tens(act_dec && cursor_q == CUR_L_TENS), .dec_ones(act_dec && cursor_q == CUR_L_ONES),
        .tens(l_tens), .ones(l_ones), .value(l_val), .in_range(l_ok)
    );

    bcd_entry_editor_edit_field #(.MAX(MAX_R)) u_field_r (
        .clk(clk), .rst_n(rst_n), .load(reload), .ld_tens(ir_tens), .ld_ones(ir_ones),
        .inc_tens(act_inc && cursor_q == CUR_R_TENS), .inc_ones(act_inc && cursor_q == CUR_R_ONES),
        .dec_tens(act_dec && cursor_q == CUR_R_TENS), .dec_ones(act_dec && cursor_q == CUR_R_ONES),
        .tens(r_tens), .ones(r_ones), .value(r_val), .in_range(r_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_EDIT;
            ST_EDIT: begin
                if (start)           state_d = ST_EDIT;
                else if (act_cancel) state_d = ST_IDLE;
                else if (act_ok)     state_d = ST_CHECK;
            end
            ST_CHECK: state_d = (l_ok && r_ok) ? ST_IDLE : ST_EDIT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        edit_active = (state_q != ST_IDLE);
        blank_mask  = (in_edit && phase_q) ? (4'b1000 >> cursor_q) : 4'b0000;
    end

    always_comb begin
        cursor_d     = cursor_q;
        load_L_d     = load_L_q;
        load_R_d     = load_R_q;
        load_valid_d = 1'b0;
        err_d        = 1'b0;
        cnt_d        = '0;
        phase_d      = 1'b0;
        if (reload)        cursor_d = CUR_L_TENS;
        else if (act_next) cursor_d = cursor_q + 2'd1;
        if (state_q == ST_CHECK) begin
            if (l_ok && r_ok) begin
                load_L_d     = l_val;
                load_R_d     = r_val;
                load_valid_d = 1'b1;
            end else begin
                err_d    = 1'b1;
                cursor_d = l_ok ? CUR_R_ONES : CUR_L_ONES;
            end
        end
        // Any accepted press restarts the blink with the digit visible.
        if (in_edit && !reload && !act_any) begin
            if (cnt_q == CW'(BLINK_HALF - 1)) begin
                phase_d = !phase_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                phase_d = phase_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cursor_q     <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            load_L_q     <= '0;
            load_R_q     <= '0;
            load_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            cursor_q     <= cursor_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            load_L_q     <= load_L_d;
            load_R_q     <= load_R_d;
            load_valid_q <= load_valid_d;
            err_q        <= err_d;
        end
    end

    assign cursor     = cursor_q;
    assign digits     = {l_tens, l_ones, r_tens, r_ones};
    assign load_L     = load_L_q;
    assign load_R     = load_R_q;
    assign load_valid = load_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_bcd_entry_editor.sv
// Bench for bcd_entry_editor: directed scenarios plus a commit scoreboard that
// pairs every load_valid strobe with a queued expected {load_L, load_R}.
module tb_bcd_entry_editor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [8:0] init_L = '0, init_R = '0;
    logic       btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_ok = 1'b0, btn_cancel = 1'b0;
    logic       edit_active, load_valid, err;
    logic [1:0] cursor;
    logic [15:0] digits;
    logic [3:0] blank_mask;
    logic [8:0] load_L, load_R;

    int n_checks = 0;
    int n_fail   = 0;
    logic [17:0] exp_q[$];

    localparam logic [4:0] B_CAN = 5'b10000, B_OK = 5'b01000, B_NEXT = 5'b00100,
                           B_INC = 5'b00010, B_DEC = 5'b00001;

    bcd_entry_editor #(.MAX_L(23), .MAX_R(59), .BLINK_HALF(50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .init_L(init_L), .init_R(init_R),
        .btn_next(btn_next), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_ok(btn_ok),
        .btn_cancel(btn_cancel), .edit_active(edit_active), .cursor(cursor), .digits(digits),
        .blank_mask(blank_mask), .load_L(load_L), .load_R(load_R), .load_valid(load_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every strobe must match the oldest queued commit.
    always @(negedge clk) begin
        if (load_valid === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL commit_unexpected: load_L=%0d load_R=%0d, no commit expected", load_L, load_R);
                n_fail++;
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({load_L, load_R} !== e) begin
                    $display("FAIL commit_value: got L=%0d R=%0d want L=%0d R=%0d",
                             load_L, load_R, e[17:9], e[8:0]);
                    n_fail++;
                end
            end
        end
    end

    task automatic press(input logic [4:0] b);
        {btn_cancel, btn_ok, btn_next, btn_inc, btn_dec} = b;
        @(negedge clk);
        {btn_cancel, btn_ok, btn_next, btn_inc, btn_dec} = '0;
    endtask

    task automatic do_start(input logic [8:0] l, input logic [8:0] r);
        start = 1'b1; init_L = l; init_R = r;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({edit_active, cursor, digits, blank_mask, load_L, load_R, load_valid, err} !== '0) begin
            $display("FAIL reset_outputs: got act=%b cur=%0d dig=%h mask=%b L=%0d R=%0d lv=%b err=%b want all zero",
                     edit_active, cursor, digits, blank_mask, load_L, load_R, load_valid, err);
            n_fail++;
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_commit;
        do_start(9'd13, 9'd45);
        n_checks++;
        if ({digits, cursor, edit_active} !== {16'h1345, 2'd0, 1'b1}) begin
            $display("FAIL basic_load: got dig=%h cur=%0d act=%b want 1345/0/1", digits, cursor, edit_active);
            n_fail++;
        end
        exp_q.push_back({9'd13, 9'd45});
        press(B_OK);
        n_checks++;
        if (load_valid !== 1'b0 || edit_active !== 1'b1) begin
            $display("FAIL basic_check_cycle: got lv=%b act=%b want 0/1", load_valid, edit_active);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (load_valid !== 1'b1) begin
            $display("FAIL basic_strobe: got lv=%b want 1", load_valid);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (load_valid !== 1'b0 || edit_active !== 1'b0 || load_L !== 9'd13 || load_R !== 9'd45) begin
            $display("FAIL basic_after: got lv=%b act=%b L=%0d R=%0d want 0/0/13/45",
                     load_valid, edit_active, load_L, load_R);
            n_fail++;
        end
    endtask

    task automatic test_err_path;
        do_start(9'd0, 9'd0);
        press(B_DEC);
        n_checks++;
        if (digits !== 16'h2000) begin
            $display("FAIL dec_tens_wrap: got %h want 2000", digits);
            n_fail++;
        end
        press(B_NEXT);
        press(B_DEC);
        n_checks++;
        if (digits !== 16'h2900 || cursor !== 2'd1) begin
            $display("FAIL dec_ones_wrap: got dig=%h cur=%0d want 2900/1", digits, cursor);
            n_fail++;
        end
        press(B_OK);
        @(negedge clk);
        n_checks++;
        if ({err, cursor, edit_active, digits} !== {1'b1, 2'd1, 1'b1, 16'h2900}) begin
            $display("FAIL err_reject: got err=%b cur=%0d act=%b dig=%h want 1/1/1/2900",
                     err, cursor, edit_active, digits);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || dut.state_q !== bcd_entry_editor_pkg::ST_EDIT) begin
            $display("FAIL err_one_cycle: got err=%b state=%0d want 0/EDIT", err, dut.state_q);
            n_fail++;
        end
        repeat (6) press(B_DEC);
        exp_q.push_back({9'd23, 9'd0});
        press(B_OK);
        repeat (2) @(negedge clk);
        n_checks++;
        if (load_L !== 9'd23 || load_R !== 9'd0 || edit_active !== 1'b0) begin
            $display("FAIL err_recommit: got L=%0d R=%0d act=%b want 23/0/0", load_L, load_R, edit_active);
            n_fail++;
        end
    endtask

    task automatic test_wrap_and_clamp;
        do_start(9'd300, 9'd100);
        n_checks++;
        if (digits !== 16'h2359) begin
            $display("FAIL init_clamp: got %h want 2359", digits);
            n_fail++;
        end
        press(B_INC);
        n_checks++;
        if (digits !== 16'h0359) begin
            $display("FAIL inc_tens_limit: got %h want 0359", digits);
            n_fail++;
        end
        repeat (3) press(B_NEXT);
        press(B_INC);
        n_checks++;
        if (digits !== 16'h0350 || cursor !== 2'd3) begin
            $display("FAIL inc_ones_nocarry: got dig=%h cur=%0d want 0350/3", digits, cursor);
            n_fail++;
        end
        press(B_NEXT);
        n_checks++;
        if (cursor !== 2'd0) begin
            $display("FAIL cursor_wrap: got %0d want 0", cursor);
            n_fail++;
        end
    endtask

    task automatic test_cancel_vs_ok;
        press(B_CAN | B_OK | B_INC);
        n_checks++;
        if (edit_active !== 1'b0 || digits !== 16'h0350) begin
            $display("FAIL cancel_priority: got act=%b dig=%h want 0/0350", edit_active, digits);
            n_fail++;
        end
        press(B_INC);
        repeat (3) @(negedge clk);
        n_checks++;
        if (load_L !== 9'd23 || load_R !== 9'd0 || digits !== 16'h0350) begin
            $display("FAIL cancel_hold: got L=%0d R=%0d dig=%h want 23/0/0350", load_L, load_R, digits);
            n_fail++;
        end
    endtask

    task automatic test_blink;
        logic [3:0] e;
        do_start(9'd12, 9'd34);
        repeat (2) press(B_NEXT);
        for (int m = 1; m <= 80; m++) begin
            @(negedge clk);
            e = (((m / 50) % 2) == 1) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (blank_mask !== e) begin
                $display("FAIL blink_cycle%0d: got %b want %b", m, blank_mask, e);
                n_fail++;
            end
        end
        press(B_INC);
        n_checks++;
        if (blank_mask !== 4'b0000 || digits !== 16'h1244) begin
            $display("FAIL blink_restart: got mask=%b dig=%h want 0000/1244", blank_mask, digits);
            n_fail++;
        end
        for (int m = 1; m <= 50; m++) begin
            @(negedge clk);
            e = (m == 50) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (blank_mask !== e) begin
                $display("FAIL blink_after_inc%0d: got %b want %b", m, blank_mask, e);
                n_fail++;
            end
        end
    endtask

    task automatic test_reset_mid_edit;
        btn_ok = 1'b1;
        @(posedge clk);
        #1 btn_ok = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({edit_active, cursor, digits, blank_mask, load_L, load_R, load_valid, err} !== '0) begin
            $display("FAIL async_reset: got act=%b cur=%0d dig=%h mask=%b L=%0d R=%0d lv=%b err=%b want all zero",
                     edit_active, cursor, digits, blank_mask, load_L, load_R, load_valid, err);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (load_L !== 9'd0 || edit_active !== 1'b0 || load_valid !== 1'b0) begin
            $display("FAIL post_reset: got L=%0d act=%b lv=%b want 0/0/0", load_L, edit_active, load_valid);
            n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_err_path();
        test_wrap_and_clamp();
        test_cancel_vs_ok();
        test_blink();
        test_reset_mid_edit();
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL commits_missing: got %0d outstanding want 0", exp_q.size());
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
